text_fetch_ctrl: RTL and testbench
==================================

Name: text_fetch_ctrl

Overview:
Text-mode fetch scheduler for the character display path. From the pixel coordinates it derives the character cell, glyph column and glyph line, then sequences a text-buffer read and a font-ROM read through a fixed 5-stage pipeline and emits a per-pixel on/off bit. It also shares the single text-buffer port with CPU writes, granting writes only during blanking.

Parameters:
SCALE, 8, magnification per glyph pixel; must be a power of two
CHARA_WIDTH, 8, glyph width in font pixels; equals the font_rdata width
CHARA_HEIGHT, 11, glyph height in font lines
CORDW, 16, signed coordinate width
COLS, 10, text columns
ROWS, 5, text rows
ADDRW, 8, text-buffer address width; must satisfy 2^ADDRW >= COLS*ROWS
CODEW, 8, character code width
FADDRW, 12, font-ROM address width; must satisfy 2^FADDRW >= 2^CODEW*CHARA_HEIGHT

Ports:
clk_pix  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
de  in  1  display enable for the current sx/sy
sx  in  CORDW  signed screen x
sy  in  CORDW  signed screen y
tb_en  out  1  text-buffer port enable
tb_we  out  1  text-buffer write enable
tb_addr  out  ADDRW  text-buffer address
tb_wdata  out  CODEW  text-buffer write data
tb_rdata  in  CODEW  text-buffer read data, synchronous, 1-cycle latency
font_addr  out  FADDRW  font-ROM address, computed as code*CHARA_HEIGHT+line
font_rdata  in  CHARA_WIDTH  glyph row, synchronous, 1-cycle latency; MSB is the leftmost pixel
cpu_req  in  1  CPU write request, level-held until ack
cpu_addr  in  ADDRW  CPU write address
cpu_wdata  in  CODEW  CPU write data
cpu_ack  out  1  write done; held high while cpu_req stays high
pix_on  out  1  glyph pixel lit, aligned with pix_de
pix_de  out  1  de delayed by LAT

Behaviour:
- Reset (async, rst_n=0): all outputs 0, pipeline valid bits 0, write FSM in IDLE. This also applies mid-write: tb_we drops immediately and no ack is issued.
- Coordinate decode (stage 0, combinational):
  - col = sx/(SCALE*CHARA_WIDTH), row = sy/(SCALE*CHARA_HEIGHT)
  - bit = (sx/SCALE) mod CHARA_WIDTH, line = (sy/SCALE) mod CHARA_HEIGHT
  - cell_ok = de & sx>=0 & sy>=0 & col<COLS & row<ROWS
- Pipeline, with edges counted from the sample edge E0. Latency LAT=5 from sampled de/sx/sy to pix_de/pix_on.
  - E1: tb_addr=row*COLS+col; tb_en=cell_ok; bit, line and cell_ok registered.
  - E2: RAM output valid.
  - E3: font_addr=tb_rdata*CHARA_HEIGHT+line registered.
  - E4: ROM output valid.
  - E5: pix_on=ok_d & font_rdata[CHARA_WIDTH-1-bit_d]; pix_de=de_d5.
- When cell_ok=0: no RAM/ROM access is issued for that pixel and pix_on=0 at E5. The pipeline never stalls.
- Arithmetic: products and sums are computed at full width, then truncated to ADDRW/FADDRW. Address overflow cannot occur under the parameter constraints.
- Write arbiter FSM:
  - IDLE: on cpu_req & !de, go to WRITE. The display has priority, so a request while de=1 waits.
  - WRITE, one cycle: tb_en=1, tb_we=1, tb_addr=cpu_addr, tb_wdata=cpu_wdata; next state ACK. If cpu_addr>=COLS*ROWS, tb_en and tb_we stay 0, but ACK still follows.
  - ACK: cpu_ack=1 until cpu_req=0, then return to IDLE.
  - de rising while in WRITE: the write completes. No conflict arises because the E1 stage carries cell_ok=0 for a de=0 sample.
- Port mux: the write FSM drives tb_* only in WRITE. Otherwise the display stage drives them.

Decomposition:
- Package text_pkg: LAT=5, CELL_W=SCALE*CHARA_WIDTH, CELL_H=SCALE*CHARA_HEIGHT, TB_DEPTH=COLS*ROWS, write-FSM state enum {IDLE, WRITE, ACK}.
- One sub-module, text_wr_arb: the CPU write FSM plus the tb_* port mux. The fetch pipeline stays in text_fetch_ctrl.

Test Plan:
- Reset check: assert rst_n=0 mid-frame with cpu_req=1 -> all outputs 0 at once; after release the FSM is in IDLE and cpu_ack=0.
- Latency check: text[0]=0x41, font[0x41*11+0]=8'h81, scan line sy=0 -> pix_on=1 for sx=0..7 and 56..63, 0 for sx=8..55; each pix_on lands exactly 5 clocks after its sx sample, with pix_de equal to de delayed 5.
- Glyph line select: sy=8 selects line 1 and sy=88 selects row 1, line 0 -> tb_addr=10 and font_addr=code*11+0.
- Arbitration: cpu_req with addr=3, data=0x5A raised while de=1 -> no tb_we until de=0; then exactly one tb_we pulse with tb_addr=3, then cpu_ack held until cpu_req drops; a later read of cell 3 shows 0x5A.
- Out-of-range write: cpu_addr=50 -> no tb_we, cpu_ack still asserted; text contents unchanged.
- Out-of-range display: sx=-1 and sx=640 with de=1 -> tb_en=0 and pix_on=0 five cycles later.

Source files
------------

// File: rtl/text_fetch_ctrl_pkg.sv
// Shared constants and types for the text-mode fetch scheduler.
// Default geometry lives here; the top may override it via parameters.
package text_pkg;

    localparam int LAT = 5;

    localparam int DEF_SCALE  = 8;
    localparam int DEF_CHARW  = 8;
    localparam int DEF_CHARH  = 11;
    localparam int DEF_COLS   = 10;
    localparam int DEF_ROWS   = 5;

    localparam int CELL_W   = DEF_SCALE * DEF_CHARW;
    localparam int CELL_H   = DEF_SCALE * DEF_CHARH;
    localparam int TB_DEPTH = DEF_COLS * DEF_ROWS;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        ACK
    } wr_state_t;

endpackage

// File: rtl/text_fetch_ctrl_if.sv
// Bundle of display, memory and CPU-write signals around the fetch scheduler.
// The slave modport is the scheduler's view; master is the environment's.
interface text_fetch_if #(
    parameter int CORDW       = 16,
    parameter int ADDRW       = 8,
    parameter int CODEW       = 8,
    parameter int FADDRW      = 12,
    parameter int CHARA_WIDTH = 8
);
    logic                     de;
    logic signed [CORDW-1:0]  sx;
    logic signed [CORDW-1:0]  sy;
    logic                     tb_en;
    logic                     tb_we;
    logic [ADDRW-1:0]         tb_addr;
    logic [CODEW-1:0]         tb_wdata;
    logic [CODEW-1:0]         tb_rdata;
    logic [FADDRW-1:0]        font_addr;
    logic [CHARA_WIDTH-1:0]   font_rdata;
    logic                     cpu_req;
    logic [ADDRW-1:0]         cpu_addr;
    logic [CODEW-1:0]         cpu_wdata;
    logic                     cpu_ack;
    logic                     pix_on;
    logic                     pix_de;

    modport slave (
        input  de, sx, sy, tb_rdata, font_rdata,
        input  cpu_req, cpu_addr, cpu_wdata,
        output tb_en, tb_we, tb_addr, tb_wdata,
        output font_addr, cpu_ack, pix_on, pix_de
    );

    modport master (
        output de, sx, sy, tb_rdata, font_rdata,
        output cpu_req, cpu_addr, cpu_wdata,
        input  tb_en, tb_we, tb_addr, tb_wdata,
        input  font_addr, cpu_ack, pix_on, pix_de
    );

endinterface

// File: rtl/text_fetch_ctrl_wr_arb.sv
// CPU write arbiter: steals the text-buffer port for one cycle in blanking
// and otherwise passes the display fetch through.
module text_wr_arb
    import text_pkg::*;
#(
    parameter int ADDRW = 8,
    parameter int CODEW = 8,
    parameter int DEPTH = TB_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_de,
    input  logic             i_cpu_req,
    input  logic [ADDRW-1:0] i_cpu_addr,
    input  logic [CODEW-1:0] i_cpu_wdata,
    input  logic             i_disp_en,
    input  logic [ADDRW-1:0] i_disp_addr,
    output logic             o_tb_en,
    output logic             o_tb_we,
    output logic [ADDRW-1:0] o_tb_addr,
    output logic [CODEW-1:0] o_tb_wdata,
    output logic             o_cpu_ack
);

    wr_state_t r_state;
    wr_state_t w_next;
    logic      w_in_range;

    assign w_in_range = 32'(i_cpu_addr) < DEPTH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        o_tb_en    = i_disp_en;
        o_tb_we    = 1'b0;
        o_tb_addr  = i_disp_addr;
        o_tb_wdata = '0;
        o_cpu_ack  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_cpu_req && !i_de) w_next = WRITE;
            end
            WRITE: begin
                // Out-of-range writes are swallowed but still acknowledged.
                o_tb_en    = w_in_range;
                o_tb_we    = w_in_range;
                o_tb_addr  = i_cpu_addr;
                o_tb_wdata = i_cpu_wdata;
                w_next     = ACK;
            end
            ACK: begin
                o_cpu_ack = 1'b1;
                if (!i_cpu_req) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: rtl/text_fetch_ctrl.sv
// Text-mode fetch scheduler: pixel coordinate -> text buffer -> font ROM
// -> lit/unlit pixel through a fixed five-stage pipeline.
module text_fetch_ctrl
    import text_pkg::*;
#(
    parameter int SCALE        = DEF_SCALE,
    parameter int CHARA_WIDTH  = DEF_CHARW,
    parameter int CHARA_HEIGHT = DEF_CHARH,
    parameter int CORDW        = 16,
    parameter int COLS         = DEF_COLS,
    parameter int ROWS         = DEF_ROWS,
    parameter int ADDRW        = 8,
    parameter int CODEW        = 8,
    parameter int FADDRW       = 12
) (
    input  logic       clk_pix,
    input  logic       rst_n,
    text_fetch_if.slave bus
);

    localparam int CW = SCALE * CHARA_WIDTH;
    localparam int CH = SCALE * CHARA_HEIGHT;
    localparam int BW = $clog2(CHARA_WIDTH);
    localparam int LW = $clog2(CHARA_HEIGHT);

    logic [31:0]       w_ux, w_uy;
    logic [31:0]       w_col, w_row, w_bit, w_line;
    logic              w_cell_ok;
    logic [BW-1:0]     w_sel;

    logic              r_en1;
    logic [ADDRW-1:0]  r_addr1;
    logic [LW-1:0]     r_line1, r_line2;
    logic [BW-1:0]     r_bit [4];
    logic [3:0]        r_ok;
    logic [FADDRW-1:0] r_faddr;
    logic              r_pix_on;
    logic [LAT-1:0]    r_de_sr;

    // Negative coordinates are rejected by cell_ok, so unsigned math is safe.
    assign w_ux   = 32'($unsigned(bus.sx));
    assign w_uy   = 32'($unsigned(bus.sy));
    assign w_col  = w_ux / CW;
    assign w_row  = w_uy / CH;
    assign w_bit  = (w_ux / SCALE) % CHARA_WIDTH;
    assign w_line = (w_uy / SCALE) % CHARA_HEIGHT;

    assign w_cell_ok = bus.de & ~bus.sx[CORDW-1] & ~bus.sy[CORDW-1]
                     & (w_col < COLS) & (w_row < ROWS);

    assign w_sel = BW'(CHARA_WIDTH - 1) - r_bit[3];

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            r_en1    <= 1'b0;
            r_addr1  <= '0;
            r_line1  <= '0;
            r_line2  <= '0;
            r_bit    <= '{default: '0};
            r_ok     <= '0;
            r_faddr  <= '0;
            r_pix_on <= 1'b0;
            r_de_sr  <= '0;
        end else begin
            r_en1    <= w_cell_ok;
            r_addr1  <= w_cell_ok ? ADDRW'(w_row * COLS + w_col) : '0;
            r_line1  <= LW'(w_line);
            r_line2  <= r_line1;
            r_bit[0] <= BW'(w_bit);
            r_bit[1] <= r_bit[0];
            r_bit[2] <= r_bit[1];
            r_bit[3] <= r_bit[2];
            r_ok     <= {r_ok[2:0], w_cell_ok};
            if (r_ok[1])
                r_faddr <= FADDRW'(32'(bus.tb_rdata) * CHARA_HEIGHT
                                   + 32'(r_line2));
            r_pix_on <= r_ok[3] & bus.font_rdata[w_sel];
            r_de_sr  <= {r_de_sr[LAT-2:0], bus.de};
        end
    end

    assign bus.font_addr = r_faddr;
    assign bus.pix_on    = r_pix_on;
    assign bus.pix_de    = r_de_sr[LAT-1];

    text_wr_arb #(
        .ADDRW (ADDRW),
        .CODEW (CODEW),
        .DEPTH (COLS * ROWS)
    ) u_arb (
        .clk         (clk_pix),
        .rst_n       (rst_n),
        .i_de        (bus.de),
        .i_cpu_req   (bus.cpu_req),
        .i_cpu_addr  (bus.cpu_addr),
        .i_cpu_wdata (bus.cpu_wdata),
        .i_disp_en   (r_en1),
        .i_disp_addr (r_addr1),
        .o_tb_en     (bus.tb_en),
        .o_tb_we     (bus.tb_we),
        .o_tb_addr   (bus.tb_addr),
        .o_tb_wdata  (bus.tb_wdata),
        .o_cpu_ack   (bus.cpu_ack)
    );

endmodule

// File: tb/tb_text_fetch_ctrl.sv
// Bench for text_fetch_ctrl: owns the text RAM and font ROM, predicts
// every pixel from the character-cell arithmetic and a shadow text copy.
module tb_text_fetch_ctrl;

    typedef struct {
        bit ok;
        int addr;
        int faddr;
        bit pon;
        bit pde;
        bit has_c;
        bit cexp;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    text_fetch_if bus ();

    text_fetch_ctrl dut (
        .clk_pix (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    logic [7:0] ram  [0:255];
    logic [7:0] font [0:4095];
    logic [7:0] txt  [0:255];
    logic       ld_en;
    logic [7:0] ld_a, ld_d;

    int   errors = 0;
    int   checks = 0;
    bit   chk_tb;
    ent_t q[$];

    always @(posedge clk) begin
        if (ld_en) begin
            ram[ld_a] <= ld_d;
        end else if (bus.tb_en) begin
            if (bus.tb_we) ram[bus.tb_addr] <= bus.tb_wdata;
            bus.tb_rdata <= ram[bus.tb_addr];
        end
    end

    always @(posedge clk) bus.font_rdata <= font[bus.font_addr];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference: cell geometry 64x88 screen pixels, 10x5 cells, glyph 8x11.
    function automatic ent_t mdl(bit d, int x, int y);
        ent_t e;
        int col, row, bt, ln, code;
        logic [7:0] g;
        e = '{default: 0};
        e.pde = d;
        if (x >= 0 && y >= 0) begin
            col = x / 64;
            row = y / 88;
            bt  = (x / 8) % 8;
            ln  = (y / 8) % 11;
            e.ok = d && col < 10 && row < 5;
            if (e.ok) begin
                e.addr  = row * 10 + col;
                code    = int'(txt[8'(e.addr)]);
                e.faddr = code * 11 + ln;
                g       = font[12'(e.faddr)];
                e.pon   = g[3'(7 - bt)];
            end
        end
        return e;
    endfunction

    task automatic step(input bit d, input int x, input int y,
                        input bit hc = 1'b0, input bit ce = 1'b0);
        ent_t e;
        @(posedge clk);
        #1;
        if (q.size() == 5) begin
            if (chk_tb) begin
                chk("tb_en", 32'(bus.tb_en), 32'(q[4].ok));
                chk("tb_we", 32'(bus.tb_we), 0);
                if (q[4].ok)
                    chk("tb_addr", 32'(bus.tb_addr), q[4].addr);
            end
            if (q[2].ok)
                chk("font_addr", 32'(bus.font_addr), q[2].faddr);
            chk("pix_de", 32'(bus.pix_de), 32'(q[0].pde));
            chk("pix_on", 32'(bus.pix_on), 32'(q[0].pon));
            if (q[0].has_c)
                chk("pix_const", 32'(bus.pix_on), 32'(q[0].cexp));
            void'(q.pop_front());
        end
        bus.de = d;
        bus.sx = 16'(x);
        bus.sy = 16'(y);
        e = mdl(d, x, y);
        e.has_c = hc;
        e.cexp  = ce;
        q.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tb_en"},  32'(bus.tb_en), 0);
        chk({tag, "_tb_we"},  32'(bus.tb_we), 0);
        chk({tag, "_tb_addr"}, 32'(bus.tb_addr), 0);
        chk({tag, "_tb_wdata"}, 32'(bus.tb_wdata), 0);
        chk({tag, "_font_addr"}, 32'(bus.font_addr), 0);
        chk({tag, "_pix_on"}, 32'(bus.pix_on), 0);
        chk({tag, "_pix_de"}, 32'(bus.pix_de), 0);
        chk({tag, "_cpu_ack"}, 32'(bus.cpu_ack), 0);
    endtask

    task automatic refill();
        ent_t z;
        z = '{default: 0};
        q.delete();
        repeat (5) q.push_back(z);
    endtask

    initial begin
        rst_n = 1'b1;
        ld_en = 1'b0;
        ld_a = '0;
        ld_d = '0;
        chk_tb = 1'b1;
        bus.de = 1'b0;
        bus.sx = '0;
        bus.sy = '0;
        bus.cpu_req = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_wdata = '0;
        for (int i = 0; i < 256; i++) txt[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 4096; i++) font[i] = 8'($urandom_range(0, 255));
        txt[0] = 8'h41;
        font[12'(8'h41 * 11)] = 8'h81;

        // Power-on reset with a pending CPU request
        #1 rst_n = 1'b0;
        bus.cpu_req = 1'b1;
        #1 chk_all_zero("rst0");
        ld_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            ld_a = 8'(i);
            ld_d = txt[i];
            @(posedge clk);
            #1;
        end
        ld_en = 1'b0;
        chk_all_zero("rst1");
        bus.cpu_req = 1'b0;
        rst_n = 1'b1;
        refill();

        // Latency: cell 0 holds 'A', glyph row 0 is 8'h81
        for (int x = 0; x < 64; x++)
            step(1'b1, x, 0, 1'b1, (x < 8 || x >= 56));

        // Line and row selection
        step(1'b1, 0, 8);
        step(1'b1, 0, 88);
        step(1'b1, 0, 168);
        step(1'b1, 639, 439);
        step(1'b1, 100, 440);

        // Off-screen and blanked samples
        step(1'b1, -1, 0);
        step(1'b1, 640, 0);
        step(1'b1, 5, -3);
        step(1'b0, 10, 10);

        // Arbitration: request held off while de=1
        step(1'b1, 5, 0);
        bus.cpu_addr  = 8'd3;
        bus.cpu_wdata = 8'h5a;
        bus.cpu_req   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, i * 64 + 5, 0);
            chk("arb_wait_ack", 32'(bus.cpu_ack), 0);
        end
        step(1'b0, 0, 0);
        chk_tb = 1'b0;
        step(1'b0, 0, 0);
        chk("arb_we", 32'(bus.tb_we), 1);
        chk("arb_en", 32'(bus.tb_en), 1);
        chk("arb_addr", 32'(bus.tb_addr), 3);
        chk("arb_wdata", 32'(bus.tb_wdata), 32'h5a);
        chk("arb_ack0", 32'(bus.cpu_ack), 0);
        txt[3] = 8'h5a;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 0, 0);
            chk("arb_ack_hold", 32'(bus.cpu_ack), 1);
            chk("arb_we_once", 32'(bus.tb_we), 0);
        end
        bus.cpu_req = 1'b0;
        step(1'b0, 0, 0);
        chk("arb_ack_drop", 32'(bus.cpu_ack), 0);
        chk_tb = 1'b1;

        // Out-of-range write: acknowledged, nothing written
        bus.cpu_addr  = 8'd50;
        bus.cpu_wdata = 8'h77;
        bus.cpu_req   = 1'b1;
        step(1'b0, 0, 0);
        chk("oor_ack0", 32'(bus.cpu_ack), 0);
        step(1'b0, 0, 0);
        chk("oor_ack", 32'(bus.cpu_ack), 1);
        bus.cpu_req = 1'b0;
        step(1'b0, 0, 0);
        chk("oor_ack_drop", 32'(bus.cpu_ack), 0);

        // Full scan of row 0 and row 4 reads back cells 3 and 7
        for (int x = 0; x < 640; x += 4) step(1'b1, x, 16);
        for (int x = 0; x < 640; x += 8) step(1'b1, x, 4 * 88 + 40);

        // Reset in the middle of a write, pipeline still full of de=1
        for (int i = 0; i < 6; i++) step(1'b1, i * 64, 0);
        bus.cpu_addr  = 8'd7;
        bus.cpu_wdata = 8'hee;
        bus.cpu_req   = 1'b1;
        step(1'b0, 0, 0);
        chk_tb = 1'b0;
        step(1'b0, 0, 0);
        chk("mw_we", 32'(bus.tb_we), 1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("mw_rst");
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("mw_hold");
        bus.cpu_req = 1'b0;
        rst_n = 1'b1;
        refill();
        chk_tb = 1'b1;
        step(1'b0, 0, 0);
        chk("mw_idle_ack", 32'(bus.cpu_ack), 0);
        step(1'b0, 0, 0);
        chk("mw_idle_we", 32'(bus.tb_we), 0);

        // Randomised frame sampling
        for (int i = 0; i < 1500; i++)
            step(($urandom_range(0, 9) != 0),
                 int'($urandom_range(0, 790)) - 70,
                 int'($urandom_range(0, 500)) - 30);
        for (int x = 448; x < 512; x += 2) step(1'b1, x, 8);
        repeat (6) step(1'b0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
